// File: rtl/vmem_linebuf.sv
// Ping-pong video line buffer: capture writes one bank while the output
// side reads the previously completed line from the other bank by column.
module vmem_linebuf #(
    parameter int                DATA_W = 12,
    parameter int                ADDR_W = 9,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_vdata_reset,
    input  logic              i_vdata_valid,
    input  logic [DATA_W-1:0] i_vdata,
    input  logic              i_line_done,
    input  logic [ADDR_W-1:0] i_column,
    output logic [DATA_W-1:0] o_vdata,
    output logic [ADDR_W:0]   o_line_len,
    output logic              o_line_ready,
    output logic              o_overflow,
    output logic [ADDR_W:0]   o_wr_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [2*DEPTH];

    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W:0]   wr_next;
    logic              wr_bank;
    logic              full;
    logic              wr_en;

    logic [ADDR_W-1:0] rd_col;
    logic              rd_bank;
    logic              rd_hit;

    // Counter never wraps, so its MSB alone means the bank holds DEPTH words
    assign full    = wr_cnt[ADDR_W];
    assign wr_en   = i_vdata_valid && !full && (i_line_done || !i_vdata_reset);
    assign wr_next = wr_cnt + {{ADDR_W{1'b0}}, wr_en};

    assign o_wr_count = wr_cnt;

    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[{wr_bank, wr_cnt[ADDR_W-1:0]}] <= i_vdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_cnt       <= '0;
            wr_bank      <= 1'b0;
            o_line_len   <= '0;
            o_line_ready <= 1'b0;
            o_overflow   <= 1'b0;
        end else if (i_line_done) begin
            o_line_len   <= wr_next;
            wr_bank      <= ~wr_bank;
            wr_cnt       <= '0;
            o_line_ready <= 1'b1;
            if (i_vdata_reset)
                o_overflow <= 1'b0;
            else if (i_vdata_valid && full)
                o_overflow <= 1'b1;
        end else if (i_vdata_reset) begin
            wr_cnt       <= '0;
            o_line_ready <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            wr_cnt       <= wr_next;
            o_line_ready <= 1'b0;
            if (i_vdata_valid && full)
                o_overflow <= 1'b1;
        end
    end

    // Read bank is always the one not being written, so no RAW hazard
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_col  <= '0;
            rd_bank <= 1'b0;
            rd_hit  <= 1'b0;
            o_vdata <= '0;
        end else begin
            rd_col  <= i_column;
            rd_bank <= ~wr_bank;
            rd_hit  <= {1'b0, i_column} < o_line_len;
            o_vdata <= rd_hit ? mem[{rd_bank, rd_col}] : FILL;
        end
    end

endmodule

// File: tb/tb_vmem_linebuf.sv
// Randomized bench for vmem_linebuf against a queue-based line model.
module tb_vmem_linebuf;

    localparam int          DW    = 12;
    localparam int          AW    = 5;
    localparam int          DEPTH = 1 << AW;
    localparam logic [11:0] FILLV = 12'hABC;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          vreset = 1'b0;
    logic          valid  = 1'b0;
    logic          done   = 1'b0;
    logic [DW-1:0] vdata  = '0;
    logic [AW-1:0] col    = '0;

    logic [DW-1:0] o_vdata;
    logic [AW:0]   o_line_len;
    logic          o_line_ready;
    logic          o_overflow;
    logic [AW:0]   o_wr_count;

    vmem_linebuf #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .FILL  (FILLV)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_vdata_reset(vreset),
        .i_vdata_valid(valid),
        .i_vdata      (vdata),
        .i_line_done  (done),
        .i_column     (col),
        .o_vdata      (o_vdata),
        .o_line_len   (o_line_len),
        .o_line_ready (o_line_ready),
        .o_overflow   (o_overflow),
        .o_wr_count   (o_wr_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: line being captured, line published for reading
    logic [DW-1:0] cur[$];
    logic [DW-1:0] pub[$];
    logic          m_ovf;
    logic          m_ready;
    logic          m_bank;
    logic [DW-1:0] s1;
    logic [DW-1:0] s2;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("vdata",    32'(o_vdata),      32'(s2));
        check("line_len", 32'(o_line_len),   32'(pub.size()));
        check("wr_count", 32'(o_wr_count),   32'(cur.size()));
        check("ready",    32'(o_line_ready), 32'(m_ready));
        check("overflow", 32'(o_overflow),   32'(m_ovf));
        check("wr_bank",  32'(dut.wr_bank),  32'(m_bank));
    endtask

    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit vr,
                       input bit ld, input int c);
        bit was_full;
        valid  = v;
        vdata  = d;
        vreset = vr;
        done   = ld;
        col    = c[AW-1:0];
        @(posedge clk);
        s2       = s1;
        s1       = (c < pub.size()) ? pub[c] : FILLV;
        m_ready  = ld;
        was_full = (cur.size() == DEPTH);
        if (ld) begin
            if (v && !was_full) cur.push_back(d);
            pub = cur;
            cur.delete();
            m_bank = ~m_bank;
            if (vr) m_ovf = 1'b0;
            else if (v && was_full) m_ovf = 1'b1;
        end else if (vr) begin
            cur.delete();
            m_ovf = 1'b0;
        end else if (v) begin
            if (was_full) m_ovf = 1'b1;
            else cur.push_back(d);
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input int c);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, c);
    endtask

    task automatic do_reset();
        valid  = 1'b0;
        vreset = 1'b0;
        done   = 1'b0;
        #2;
        rst_n  = 1'b0;
        cur.delete();
        pub.delete();
        m_ovf   = 1'b0;
        m_ready = 1'b0;
        m_bank  = 1'b0;
        s2      = '0;
        #1;
        check_all();
        s1 = FILLV;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        // Reset in the middle of a line
        for (int i = 0; i < 10; i++) cyc(1, 12'(i + 100), 0, 0, 0);
        do_reset();
        idle(2, 3);

        // Basic line and reads past the end
        for (int i = 1; i <= 10; i++) cyc(1, 12'(i), 0, 0, 0);
        cyc(0, '0, 0, 1, 0);
        for (int c = 0; c <= 12; c++) cyc(0, '0, 0, 0, c);
        idle(2, 0);

        // Overflow, then full-length line intact
        for (int i = 0; i < DEPTH + 3; i++) cyc(1, 12'(i), 0, 0, 0);
        cyc(0, '0, 0, 1, 0);
        for (int c = 0; c < DEPTH; c++) cyc(0, '0, 0, 0, c);
        cyc(0, '0, 1, 0, 0);
        idle(2, 0);

        // Read col 5 across a swap between lines A and B
        for (int i = 0; i < 8; i++) cyc(1, 12'($urandom), 0, 0, 5);
        cyc(0, '0, 0, 1, 5);
        for (int i = 0; i < 8; i++) cyc(1, 12'($urandom), 0, 0, 5);
        cyc(0, '0, 0, 1, 5);
        idle(4, 5);

        // Valid with reset drops; valid with done counts
        for (int i = 0; i < 7; i++) cyc(1, 12'(i + 50), 0, 0, 0);
        cyc(1, 12'h777, 1, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 12'(i + 60), 0, 0, i);
        cyc(1, 12'h0EE, 0, 1, 0);
        for (int c = 0; c < 9; c++) cyc(0, '0, 0, 0, c);

        // Back-to-back empty publishes
        cyc(0, '0, 0, 1, 0);
        cyc(0, '0, 0, 1, 1);
        for (int c = 0; c < 6; c++) cyc(0, '0, 0, 0, c);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 7, 12'($urandom),
                $urandom_range(0, 59) == 0, $urandom_range(0, 44) == 0,
                int'($urandom_range(0, DEPTH - 1)));
        end
        idle(3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
